// File: rtl/button_event_arbiter.sv
// Collects debounced rise/fall pulses into one-deep per-channel slots and
// serialises them onto a valid/ready event stream with round-robin arbitration.
module button_event_arbiter #(
    parameter int N_CH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_CH-1:0]           rise,
    input  logic [N_CH-1:0]           fall,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [$clog2(N_CH)-1:0]   ev_ch,
    output logic                      ev_type,
    output logic [N_CH-1:0]           overflow,
    input  logic                      overflow_clr
);

    localparam int CW = $clog2(N_CH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   ev_ch_reg, ev_ch_next;
    logic            ev_type_reg, ev_type_next;
    logic [CW-1:0]   last_grant_reg, last_grant_next;
    logic [N_CH-1:0] slot_occ_reg, slot_occ_next;
    logic [N_CH-1:0] slot_type_reg, slot_type_next;
    logic [N_CH-1:0] overflow_reg, overflow_next;

    logic            any_occ;
    logic            found;
    logic [CW-1:0]   winner;
    logic [CW-1:0]   cand;
    int              sum;
    logic            load;
    logic [N_CH-1:0] freed;
    logic [N_CH-1:0] pulse;
    logic [N_CH-1:0] drop;

    assign any_occ = |slot_occ_reg;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = 0;
        cand   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            sum = int'(last_grant_reg) + k;
            if (sum >= N_CH) begin
                sum = sum - N_CH;
            end
            cand = CW'(sum);
            if (!found && slot_occ_reg[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (any_occ) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (ev_ready) begin
                    if (any_occ) begin
                        load = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
        ev_ch_next      = load ? winner : ev_ch_reg;
        ev_type_next    = load ? slot_type_reg[winner] : ev_type_reg;
        last_grant_next = load ? winner : last_grant_reg;
    end

    // A pulse landing on a slot that is freed this edge refills it; otherwise
    // an occupied slot keeps its older event and the new pulse is lost.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
            assign freed[gi]          = load && (winner == CW'(gi));
            assign pulse[gi]          = rise[gi] | fall[gi];
            assign drop[gi]           = pulse[gi] && slot_occ_reg[gi] && !freed[gi];
            assign slot_occ_next[gi]  = pulse[gi] ? 1'b1 : (slot_occ_reg[gi] && !freed[gi]);
            assign slot_type_next[gi] = (pulse[gi] && !drop[gi]) ? rise[gi] : slot_type_reg[gi];
            assign overflow_next[gi]  = drop[gi] || (rise[gi] && fall[gi]) ||
                                        (overflow_reg[gi] && !overflow_clr);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= EMPTY;
            ev_ch_reg      <= '0;
            ev_type_reg    <= 1'b0;
            last_grant_reg <= CW'(N_CH - 1);
            slot_occ_reg   <= '0;
            slot_type_reg  <= '0;
            overflow_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            ev_ch_reg      <= ev_ch_next;
            ev_type_reg    <= ev_type_next;
            last_grant_reg <= last_grant_next;
            slot_occ_reg   <= slot_occ_next;
            slot_type_reg  <= slot_type_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign ev_valid = (state_reg == FULL);
    assign ev_ch    = ev_ch_reg;
    assign ev_type  = ev_type_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_button_event_arbiter;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] rise = '0;
    logic [N-1:0] fall = '0;
    logic         ev_valid;
    logic         ev_ready = 1'b0;
    logic [1:0]   ev_ch;
    logic         ev_type;
    logic [N-1:0] overflow;
    logic         overflow_clr = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int hs_count = 0;

    // Behavioural model state
    bit           m_occ [N];
    bit           m_type[N];
    logic [N-1:0] m_ovf;
    bit           m_valid;
    int           m_ch;
    bit           m_typ;
    int           m_last;

    button_event_arbiter #(.N_CH(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .rise         (rise),
        .fall         (fall),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_ch        (ev_ch),
        .ev_type      (ev_type),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_occ[i]  = 0;
            m_type[i] = 0;
        end
        m_ovf   = '0;
        m_valid = 0;
        m_ch    = 0;
        m_typ   = 0;
        m_last  = N - 1;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] f,
                              input logic rdy, input logic clr);
        int win;
        bit hs;
        win = -1;
        hs  = m_valid && rdy;
        if (!m_valid || hs) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (win < 0 && m_occ[c]) win = c;
            end
        end
        if (win >= 0) begin
            m_valid = 1;
            m_ch    = win;
            m_typ   = m_type[win];
            m_last  = win;
        end else if (hs) begin
            m_valid = 0;
        end
        if (clr) m_ovf = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i] || f[i]) begin
                if (m_occ[i] && win != i) begin
                    m_ovf[i] = 1'b1;
                end else begin
                    m_occ[i]  = 1;
                    m_type[i] = r[i];
                    if (r[i] && f[i]) m_ovf[i] = 1'b1;
                end
            end else if (win == i) begin
                m_occ[i] = 0;
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] f,
                         input logic rdy, input logic clr);
        bit pre_hs;
        rise = r;
        fall = f;
        ev_ready = rdy;
        overflow_clr = clr;
        pre_hs = ev_valid && rdy && !reset;
        if (pre_hs) begin
            hs_count++;
            $display("event ch=%0d type=%0d t=%0t", ev_ch, ev_type, $time);
        end
        @(posedge clock);
        if (reset) model_reset();
        else model_step(r, f, rdy, clr);
        #1;
        check("valid", int'(ev_valid), int'(m_valid));
        if (m_valid) begin
            check("ch", int'(ev_ch), m_ch);
            check("type", int'(ev_type), int'(m_typ));
        end
        check("overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(4'($urandom), 4'($urandom), 1'b1, 1'b0);
        cycle(4'($urandom), 4'($urandom), 1'b1, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clock);
        #1;
        check("rst_valid", int'(ev_valid), 0);
        check("rst_ch", int'(ev_ch), 0);
        check("rst_type", int'(ev_type), 0);
        check("rst_ovf", int'(overflow), 0);

        // Single event: two-edge latency
        do_reset();
        cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
        check("single_lat0", int'(ev_valid), 0);
        cycle('0, '0, 1'b1, 1'b0);
        check("single_valid", int'(ev_valid), 1);
        check("single_ch", int'(ev_ch), 2);
        check("single_type", int'(ev_type), 1);
        cycle('0, '0, 1'b1, 1'b0);
        check("single_done", int'(ev_valid), 0);

        // Round-robin order
        do_reset();
        cycle(4'b1111, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle('0, '0, 1'b1, 1'b0);
            check("rr_valid", int'(ev_valid), 1);
            check("rr_ch", int'(ev_ch), k);
        end
        cycle(4'b0101, '0, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        check("rr2_first", int'(ev_ch), 0);
        cycle('0, '0, 1'b1, 1'b0);
        check("rr2_second", int'(ev_ch), 2);

        // Backpressure with refill and overflow
        do_reset();
        cycle('0, 4'b0010, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0);
        cycle('0, 4'b0010, 1'b0, 1'b0);
        check("bp_no_ovf", int'(overflow), 0);
        repeat (5) cycle('0, '0, 1'b0, 1'b0);
        check("bp_hold_ch", int'(ev_ch), 1);
        check("bp_hold_type", int'(ev_type), 0);
        cycle('0, 4'b0010, 1'b0, 1'b0);
        check("bp_ovf", int'(overflow), 4'b0010);
        repeat (2) cycle('0, '0, 1'b0, 1'b0);
        hs_count = 0;
        repeat (5) cycle('0, '0, 1'b1, 1'b0);
        check("bp_delivered", hs_count, 2);

        // Same-edge refill on channel 3
        do_reset();
        cycle(4'b1000, '0, 1'b1, 1'b0);
        cycle(4'b1000, '0, 1'b1, 1'b0);
        check("refill_ovf", int'(overflow), 0);
        check("refill_first", int'(ev_ch), 3);
        cycle('0, '0, 1'b1, 1'b0);
        check("refill_second_v", int'(ev_valid), 1);
        check("refill_second_ch", int'(ev_ch), 3);

        // Overflow clear racing a new overflow
        do_reset();
        cycle(4'b0010, 4'b0010, 1'b1, 1'b0);
        check("clr_pre", int'(overflow), 4'b0010);
        cycle(4'b0001, 4'b0001, 1'b1, 1'b1);
        check("clr_race", int'(overflow), 4'b0001);
        cycle('0, '0, 1'b1, 1'b1);
        check("clr_alone", int'(overflow), 4'b0000);

        // Asynchronous reset mid-operation
        do_reset();
        cycle(4'b1111, '0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0);
        check("mid_valid_before", int'(ev_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_valid", int'(ev_valid), 0);
        cycle('0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle('0, '0, 1'b1, 1'b0);
            check("mid_no_events", int'(ev_valid), 0);
        end

        // Randomized run
        do_reset();
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] r, f;
            r = 4'($urandom) & 4'($urandom) & 4'($urandom);
            f = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            else reset = 1'b0;
            cycle(r, f, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        reset = 1'b0;
        repeat (10) cycle('0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of debounced button channels (legal range 2..16).
REQ-002 The block SHALL have port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port rise, input, N_CH bits: per-channel one-cycle rising-edge pulses from the debounce stage.
REQ-005 The block SHALL have port fall, input, N_CH bits: per-channel one-cycle falling-edge pulses from the debounce stage.
REQ-006 The block SHALL have port ev_valid, output, 1 bit: an event is presented on ev_ch/ev_type.
REQ-007 The block SHALL have port ev_ready, input, 1 bit: the consumer accepts the event; a handshake is ev_valid && ev_ready at a clock edge.
REQ-008 The block SHALL have port ev_ch, output, $clog2(N_CH) bits: channel index of the presented event.
REQ-009 The block SHALL have port ev_type, output, 1 bit: 1 = rise, 0 = fall.
REQ-010 The block SHALL have port overflow, output, N_CH bits: sticky per-channel lost-event flags.
REQ-011 The block SHALL have port overflow_clr, input, 1 bit: clears all overflow bits.

Function
REQ-012 Each channel SHALL own a one-deep pending slot (occupied bit plus type bit), captured at the edge where rise[i] or fall[i] is sampled high.
REQ-013 The output stage SHALL be a two-state machine: EMPTY (ev_valid=0) and FULL (ev_valid=1).
REQ-014 EMPTY->FULL SHALL occur at the first edge where any slot is occupied; the selected slot SHALL be freed at that same edge.
REQ-015 In FULL with a handshake, the stage SHALL load the next winner at that edge if any slot is occupied (stay FULL, one event per cycle), otherwise go to EMPTY.
REQ-016 In FULL without a handshake, ev_ch and ev_type SHALL hold stable and no slot SHALL be freed.
REQ-017 Latency SHALL be exactly 2 edges: a pulse sampled at edge k gives ev_valid=1 after edge k+1 when the stage is free and no other slot is pending.
REQ-018 Arbitration SHALL be round-robin: the search SHALL start at last_grant+1 modulo N_CH, and the first occupied slot found SHALL win; last_grant SHALL update on each load.
REQ-019 A pulse on a channel whose slot is occupied and not freed at that edge SHALL be dropped, and the slot SHALL keep the older event.
  - overflow[i] SHALL set at that edge.
REQ-020 A pulse on a channel whose slot is freed at that same edge SHALL be captured into the slot with no overflow.
REQ-021 rise[i] and fall[i] both high in one cycle SHALL capture rise and SHALL set overflow[i].
REQ-022 overflow_clr SHALL zero all overflow bits at the next edge.
  - An overflow event at that same edge SHALL win, leaving its bit set.

Reset
REQ-023 While reset=1, all of the following SHALL hold asynchronously:
  - ev_valid=0, ev_ch=0, ev_type=0.
  - overflow=0.
  - All slots empty.
  - last_grant=N_CH-1, so channel 0 has first priority.
  - State EMPTY.
REQ-024 Events in slots or in the output stage SHALL be discarded when reset is asserted mid-operation.
REQ-025 Pulses sampled while reset=1 SHALL be ignored; the first capture SHALL occur at the first edge after deassertion.

Verification
REQ-026 Single event: rise[2] pulsed at edge 5, ev_ready=1 -> ev_valid=1, ev_ch=2, ev_type=1 after edge 6; ev_valid=0 after edge 7.
REQ-027 Round-robin: rise=4'b1111 at edge 5, ev_ready=1 -> ev_ch sequence 0,1,2,3 on consecutive cycles; then rise=4'b0101 -> order 0,2.
REQ-028 Backpressure: fall[1] then ev_ready=0 for 10 cycles -> ev_ch=1, ev_type=0 held stable; a second fall[1] during the stall -> slot filled, no overflow; a third fall[1] -> overflow=4'b0010, and exactly two events delivered after ev_ready=1.
REQ-029 Same-edge refill: slot 3 drained at an edge where rise[3]=1 -> new event captured, overflow[3]=0.
REQ-030 Overflow clear race: overflow_clr=1 at the same edge as a new overflow on channel 0 -> overflow=4'b0001; overflow_clr alone at the next edge -> 4'b0000.
REQ-031 Reset mid-operation: reset=1 asynchronously while ev_valid=1 with 3 slots pending -> ev_valid=0 immediately; no events appear after release without new pulses.
